// File: rtl/mul_div.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide.
// Define YADAN_FAST_MUL_EN to replace the multiply loop with a single-cycle 33x33 signed product.
module mul_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        mul_or_div_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        reg1_sign_i,
    input  logic        reg2_sign_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        done_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;

    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;

    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;

`ifdef YADAN_FAST_MUL_EN
    logic [32:0] r_a33;
    logic [32:0] r_b33;
    logic [63:0] w_fast_prod;
`endif

    logic        w_neg1;
    logic        w_neg2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_div0;
    logic        w_last;

    logic [63:0] w_acc_nxt;
    logic [63:0] w_prod_fin;
    logic [33:0] w_shift;
    logic [33:0] w_sub;
    logic        w_qbit;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;

    // Magnitudes are unsigned, so 0x80000000 negates to itself and is read as 2^31.
    assign w_neg1 = reg1_sign_i & dividend_i[31];
    assign w_neg2 = reg2_sign_i & divisor_i[31];
    assign w_mag1 = w_neg1 ? (~dividend_i + 32'd1) : dividend_i;
    assign w_mag2 = w_neg2 ? (~divisor_i + 32'd1) : divisor_i;
    assign w_div0 = mul_or_div_i & (divisor_i == '0);
    assign w_last = (r_cnt == 6'd31);

    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_fin = r_neg_q ? (~w_acc_nxt + 64'd1) : w_acc_nxt;

    // Trial subtraction is one bit wider than the remainder so bit 33 acts as the borrow.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_sub     = w_shift - {2'b00, r_dvsr};
    assign w_qbit    = ~w_sub[33];
    assign w_rem_nxt = w_qbit ? w_sub[32:0] : w_shift[32:0];
    assign w_quo_nxt = {r_quo[30:0], w_qbit};
    assign w_q_fin   = r_neg_q ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
    assign w_r_fin   = r_neg_r ? (~w_rem_nxt[31:0] + 32'd1) : w_rem_nxt[31:0];

`ifdef YADAN_FAST_MUL_EN
    assign w_fast_prod = {{31{r_a33[32]}}, r_a33} * {{31{r_b33[32]}}, r_b33};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stallreq_o  = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                stallreq_o = start_i;
                if (start_i) begin
                    w_state_nxt = w_div0 ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stallreq_o = 1'b1;
`ifdef YADAN_FAST_MUL_EN
                if (w_last || !r_is_div) begin
                    w_state_nxt = S_DONE;
                end
`else
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (annul_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
`ifdef YADAN_FAST_MUL_EN
            r_a33    <= '0;
            r_b33    <= '0;
`endif
        end else if (!annul_i) begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cnt    <= '0;
                        r_is_div <= mul_or_div_i;
                        r_neg_q  <= w_neg1 ^ w_neg2;
                        r_neg_r  <= w_neg1;
                        r_acc    <= '0;
                        r_mcand  <= {32'd0, w_mag1};
                        r_mplier <= w_mag2;
                        r_rem    <= '0;
                        r_quo    <= w_mag1;
                        r_dvsr   <= w_mag2;
`ifdef YADAN_FAST_MUL_EN
                        r_a33    <= {w_neg1, dividend_i};
                        r_b33    <= {w_neg2, divisor_i};
`endif
                        if (w_div0) begin
                            r_result <= {32'hFFFF_FFFF, dividend_i};
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_is_div) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (w_last) begin
                            r_result <= {w_q_fin, w_r_fin};
                        end
                    end else begin
`ifdef YADAN_FAST_MUL_EN
                        r_result <= w_fast_prod;
`else
                        r_acc    <= w_acc_nxt;
                        r_mcand  <= {r_mcand[62:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[31:1]};
                        if (w_last) begin
                            r_result <= w_prod_fin;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_mul_div.sv
// Scoreboard bench for mul_div: driver pushes model results, monitor pops on done_o.
module tb_mul_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        mul_or_div_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        reg1_sign_i;
    logic        reg2_sign_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        done_o;
    logic        stallreq_o;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          issue;
    } want_t;

    want_t       want_q[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] last_result = '0;

    mul_div dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mul_or_div_i (mul_or_div_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .reg1_sign_i  (reg1_sign_i),
        .reg2_sign_i  (reg2_sign_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .done_o       (done_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    endtask

    // RV32M semantics from 64-bit integer arithmetic (division truncates toward zero).
    function automatic logic [63:0] ref_model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                              input logic s1, input logic s2);
        longint      sa;
        longint      sb;
        logic [63:0] qv;
        logic [63:0] rv;
        sa = s1 ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s2 ? longint'($signed(b)) : longint'({32'd0, b});
        if (!m) return 64'(sa * sb);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        qv = 64'(sa / sb);
        rv = 64'(sa % sb);
        return {qv[31:0], rv[31:0]};
    endfunction

    function automatic int want_lat(input logic m, input logic [31:0] b);
        if (m && b == 32'd0) return 1;
`ifdef YADAN_FAST_MUL_EN
        if (!m) return 2;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble();
        mul_or_div_i = 1'($urandom_range(0, 1));
        dividend_i   = $urandom;
        divisor_i    = $urandom;
        reg1_sign_i  = 1'($urandom_range(0, 1));
        reg2_sign_i  = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                          input logic s1, input logic s2);
        want_t w;
        bit    seen;
        bit    stall_ok;
        @(posedge clk); #1;
        mul_or_div_i = m;
        dividend_i   = a;
        divisor_i    = b;
        reg1_sign_i  = s1;
        reg2_sign_i  = s2;
        start_i      = 1'b1;
        w.res   = ref_model(m, a, b, s1, s2);
        w.lat   = want_lat(m, b);
        w.issue = cyc;
        want_q.push_back(w);
        last_result = w.res;
        #1;
        chk("stall_cycle0", 64'(stallreq_o), 64'd1);
        seen     = 1'b0;
        stall_ok = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (stallreq_o !== 1'b1) stall_ok = 1'b0;
                scramble();
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("stall_during_op", 64'(stall_ok), 64'd1);
        chk("stall_in_done", 64'(stallreq_o), 64'd0);
        start_i = 1'b0;
        if (!seen) void'(want_q.pop_back());
    endtask

    // Abort a divide in a given cycle using annul (use_rst=0) or reset (use_rst=1).
    task automatic abort_op(input int at_cycle, input bit use_rst);
        @(posedge clk); #1;
        mul_or_div_i = 1'b1;
        dividend_i   = 32'd1000;
        divisor_i    = 32'd3;
        reg1_sign_i  = 1'b0;
        reg2_sign_i  = 1'b0;
        start_i      = 1'b1;
        repeat (at_cycle) begin @(posedge clk); #1; end
        start_i = 1'b0;
        if (use_rst) rst = 1'b1;
        else annul_i = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        annul_i = 1'b0;
        if (use_rst) last_result = '0;
        chk(use_rst ? "rst_stall" : "annul_stall", 64'(stallreq_o), 64'd0);
        chk(use_rst ? "rst_result" : "annul_hold", result_o, last_result);
        chk(use_rst ? "rst_done" : "annul_done", 64'(done_o), 64'd0);
        repeat (40) @(posedge clk);
    endtask

    initial begin : monitor
        want_t w;
        logic  prev_done;
        prev_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin
                if (want_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got done_o=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    w = want_q.pop_front();
                    chk("result", result_o, w.res);
                    chk("latency", 64'(cyc - w.issue), 64'(w.lat));
                    chk("done_one_cycle", 64'(prev_done), 64'd0);
                end
            end
            prev_done = done_o;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within 1ms");
        $fatal(1, "simulation timeout");
    end

    initial begin : driver
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        mul_or_div_i = 1'b0;
        dividend_i   = '0;
        divisor_i    = '0;
        reg1_sign_i  = 1'b0;
        reg2_sign_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_result", result_o, 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_stall", 64'(stallreq_o), 64'd0);

        run_op(1'b0, 32'd7,          32'd6,          1'b0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF,  32'h0000_0002,  1'b1, 1'b1);
        run_op(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  1'b1, 1'b1);
        run_op(1'b1, 32'd100,        32'd7,          1'b0, 1'b0);
        run_op(1'b1, 32'h64,         32'd0,          1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1);
        run_op(1'b1, 32'h8000_0000,  32'd0,          1'b1, 1'b1);

        abort_op(10, 1'b0);
        run_op(1'b1, 32'd1000, 32'd3, 1'b0, 1'b0);
        abort_op(20, 1'b1);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_op(1'($urandom_range(0, 1)), pick(), pick(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 64'(want_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_div.md
# mul_div

Multi-cycle integer multiply/divide unit for the RV32M instructions. It sits beside the execute stage: execute drives a level-held start request with the operands and sign mode. This block iterates, then returns a 64-bit result with a one-cycle done pulse. Execute selects the high or low word of that result. While a request is pending, `stallreq_o` freezes the pipeline.

## Interface
Parameters:
- none (operand width fixed at 32 by `RegBus`, result at 64 by `DoubleRegBus`)

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start_i`  in  1  request; held high by execute until it sees `done_o`
- `mul_or_div_i`  in  1  `MUL` (1'b0) multiply, `DIV` (1'b1) divide
- `dividend_i`  in  32  operand 1 (multiplicand / dividend)
- `divisor_i`  in  32  operand 2 (multiplier / divisor)
- `reg1_sign_i`  in  1  `Signed` (1'b1) treats operand 1 as two's complement
- `reg2_sign_i`  in  1  `Signed` (1'b1) treats operand 2 as two's complement
- `annul_i`  in  1  cancel in-flight operation (interrupt/flush)
- `result_o`  out  64  multiply: full product; divide: {quotient, remainder}
- `done_o`  out  1  result valid, exactly one cycle
- `stallreq_o`  out  1  pipeline stall request

## Operation
- FSM states:
  - IDLE: if `start_i` is high, latch the operands and mode.
  - CALC: iterate.
  - DONE: present the result for one cycle, then return to IDLE.
- IDLE→CALC on `start_i`. Divide with `divisor_i` == 0 goes IDLE→DONE directly.
- Operands latched at start; input changes during CALC/DONE ignored.
- Sign handling:
  - neg1 = `reg1_sign_i` & op1[31]; neg2 = `reg2_sign_i` & op2[31].
  - The datapath runs on magnitudes; a magnitude of 0x80000000 is treated as unsigned 2^31.
- Multiply:
  - Radix-2 shift-add over 32 steps, 64-bit accumulator.
  - Final product negated (64-bit two's complement) if neg1^neg2.
- Divide:
  - Restoring division over 32 steps, one quotient bit per step, 33-bit partial remainder.
  - Quotient negated if neg1^neg2; remainder negated if neg1.
- Divide by zero: quotient 0xFFFFFFFF, remainder = original `dividend_i` (unmodified).
- Signed overflow 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 through the normal path (no special case).
- Step counter: 6 bits, cleared on entering CALC; CALC exits when the counter reaches 31 after its step.
- `stallreq_o` = (IDLE & `start_i`) | CALC. It is low in DONE so the pipeline advances in the done cycle.
- `annul_i`: from any state go to IDLE next edge. `result_o` holds its old value. `done_o` must not assert for the annulled op.
- Priority per edge: `rst` > `annul_i` > FSM.

## Timing
- Reset values: state IDLE, `result_o` 0, `done_o` 0, counter 0. `stallreq_o` follows `start_i` combinationally.
- `done_o` and `result_o` are registered; `done_o` = (state == DONE).
- Latency, with cycle 0 = first cycle `start_i` is high in IDLE:
  - Iterative op: `done_o` high in cycle 33.
  - Divide by zero: `done_o` high in cycle 1.
- Execute deasserts `start_i` in the DONE cycle. DONE never accepts a new start; the next request is sampled in IDLE the following cycle. Back-to-back ops therefore cost latency + 1.
- If `start_i` stays high in DONE, it is ignored in that cycle and restarts the operation from IDLE in the next cycle.
- Reset or annul mid-CALC discards partial state; a fresh start afterwards computes normally.

## Configuration
- `YADAN_FAST_MUL_EN` defined:
  - Multiply uses a single-cycle 33x33 signed product of the sign-extended operands, registered in one CALC cycle.
  - `done_o` for multiply is high in cycle 2.
  - Divide is unchanged.
- Not defined: multiply uses the 32-step shift-add path (cycle 33).
- `result_o` values are identical in both builds.

## Test plan
- MUL unsigned 7 × 6 → `result_o` 0x00000000_0000002A. `done_o` high for exactly one cycle, in cycle 33 (cycle 2 with `YADAN_FAST_MUL_EN`). `stallreq_o` high in cycles 0-32.
- Signed×signed 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF_FFFFFFFE. Signed×unsigned 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF_00000001.
- DIV signed 0xFFFFFFF9 / 0x00000002 (−7/2) → 0xFFFFFFFD_FFFFFFFF. DIVU 100/7 → 0x0000000E_00000002.
- DIVU 0x64 / 0 → 0xFFFFFFFF_00000064 with `done_o` in cycle 1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000_00000000.
- `annul_i` pulsed in cycle 10 of a divide → state IDLE in cycle 11, no `done_o`, `stallreq_o` low once `start_i` drops. `rst` asserted in cycle 20 gives the same behaviour.
- Back-to-back MUL then DIV with `start_i` re-raised the cycle after `done_o` → both results correct. The second start is sampled in IDLE, and the second `done_o` follows the first by 34 cycles.
